// File: rtl/eth_recv.sv
// MII nibble receiver: preamble/SFD detect, destination filter, header strip, CRC-32 check, FCS strip.
// Payload byte N leaves 1 cycle after byte N+5 completes; no backpressure, the sink must take every beat.
module eth_recv #(
  parameter logic ACCEPT_BCAST = 1'b1,
  parameter logic PROMISC      = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [47:0] local_mac,
  input  logic [3:0]  rxd,
  input  logic        rx_dv,
  input  logic        rx_er,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  output logic [47:0] rx_dst_mac,
  output logic [47:0] rx_src_mac,
  output logic [15:0] rx_eth_type,
  output logic        rx_hdr_valid,
  output logic [15:0] good_frames,
  output logic [15:0] bad_frames
);

  typedef enum logic [2:0] {IDLE, PREAMBLE, HEADER, PAYLOAD, DROP} state_t;

  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
  localparam logic [47:0] BCAST_MAC   = 48'hFFFF_FFFF_FFFF;

  state_t          state;
  state_t          next_state;
  logic            phase;
  logic [3:0]      lo_nib;
  logic [3:0]      byte_idx;
  logic [31:0]     crc;
  logic            err;
  logic [4:0][7:0] dline;
  logic [2:0]      dcount;

  logic [7:0]      cur_byte;
  logic            byte_done;
  logic [31:0]     crc_upd;
  logic [47:0]     dst_full;
  logic            dst_ok;
  logic            frame_bad;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  assign cur_byte  = {rxd, lo_nib};
  assign byte_done = rx_dv && phase && (state == HEADER || state == PAYLOAD);
  assign crc_upd   = crc_byte(crc, cur_byte);
  assign dst_full  = {rx_dst_mac[39:0], cur_byte};
  assign dst_ok    = PROMISC || (dst_full == local_mac) || (ACCEPT_BCAST && dst_full == BCAST_MAC);
  // A dangling nibble means the frame ended mid-byte.
  assign frame_bad = (crc != CRC_RESIDUE) || err || phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (rx_dv) next_state = (rxd == 4'h5) ? PREAMBLE : DROP;
      PREAMBLE: begin
        if (!rx_dv)              next_state = IDLE;
        else if (rxd == 4'hD)    next_state = HEADER;
        else if (rxd != 4'h5)    next_state = DROP;
      end
      HEADER: begin
        if (!rx_dv)                                    next_state = IDLE;
        else if (phase && byte_idx == 4'd5 && !dst_ok) next_state = DROP;
        else if (phase && byte_idx == 4'd13)           next_state = PAYLOAD;
      end
      PAYLOAD:  if (!rx_dv) next_state = IDLE;
      DROP:     if (!rx_dv) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_axis_tdata  <= 8'h00;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      rx_dst_mac    <= 48'h0;
      rx_src_mac    <= 48'h0;
      rx_eth_type   <= 16'h0;
      rx_hdr_valid  <= 1'b0;
      good_frames   <= 16'h0;
      bad_frames    <= 16'h0;
      phase         <= 1'b0;
      lo_nib        <= 4'h0;
      byte_idx      <= 4'h0;
      crc           <= CRC_INIT;
      err           <= 1'b0;
      dline         <= '0;
      dcount        <= 3'd0;
    end else begin
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      rx_hdr_valid  <= 1'b0;
      case (state)
        PREAMBLE: begin
          if (rx_dv && rxd == 4'hD) begin
            phase    <= 1'b0;
            byte_idx <= 4'h0;
            err      <= 1'b0;
            crc      <= CRC_INIT;
            dcount   <= 3'd0;
          end
        end
        HEADER, PAYLOAD: begin
          if (rx_dv) begin
            if (rx_er) err <= 1'b1;
            phase <= ~phase;
            if (!phase) lo_nib <= rxd;
            else        crc    <= crc_upd;
          end
          if (!rx_dv && state == HEADER) bad_frames <= bad_frames + 16'd1;
          if (byte_done && state == HEADER) begin
            byte_idx <= byte_idx + 4'd1;
            if (byte_idx < 4'd6)       rx_dst_mac  <= dst_full;
            else if (byte_idx < 4'd12) rx_src_mac  <= {rx_src_mac[39:0], cur_byte};
            else                       rx_eth_type <= {rx_eth_type[7:0], cur_byte};
            if (byte_idx == 4'd13) rx_hdr_valid <= 1'b1;
          end
          // Five-byte delay keeps the FCS from ever reaching the output.
          if (byte_done && state == PAYLOAD) begin
            dline <= {dline[3:0], cur_byte};
            if (dcount == 3'd5) begin
              m_axis_tdata  <= dline[4];
              m_axis_tvalid <= 1'b1;
            end else begin
              dcount <= dcount + 3'd1;
            end
          end
          if (!rx_dv && state == PAYLOAD) begin
            if (dcount == 3'd5) begin
              m_axis_tdata  <= dline[4];
              m_axis_tvalid <= 1'b1;
              m_axis_tlast  <= 1'b1;
              m_axis_tuser  <= frame_bad;
              if (frame_bad) bad_frames  <= bad_frames + 16'd1;
              else           good_frames <= good_frames + 16'd1;
            end else begin
              bad_frames <= bad_frames + 16'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/eth_recv.md
# eth_recv

Receive-side counterpart of the Ethernet transmit chain. Takes the MII-style nibble stream from the PHY side (`rxd`/`rx_dv`/`rx_er`), detects preamble/SFD and assembles bytes. It filters on destination MAC, strips the 14-byte Ethernet header and the 4-byte FCS, and checks CRC-32. It emits the payload as a byte stream with `tlast`/`tuser` for the IP/ARP receive parsers. One nibble per `clk` cycle; `clk` is the recovered receive data clock.

## Interface
- `ACCEPT_BCAST`, 1: accept destination `48'hFFFFFFFFFFFF` in addition to `local_mac`.
- `PROMISC`, 0: 1 = accept any destination MAC.
- `clk` in 1: receive data clock, one nibble per rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `local_mac` in 48: own MAC address; must be stable during a frame.
- `rxd` in 4: receive nibble, low nibble of each byte first.
- `rx_dv` in 1: receive data valid.
- `rx_er` in 1: PHY receive error.
- `m_axis_tdata` out 8: payload byte.
- `m_axis_tvalid` out 1: one-cycle strobe per payload byte. No backpressure; the sink must accept every beat.
- `m_axis_tlast` out 1: last payload byte of the frame; qualified by `tvalid`.
- `m_axis_tuser` out 1: frame error; valid only with `tlast`. 1 = bad FCS, `rx_er` seen, or odd nibble count.
- `rx_dst_mac`, `rx_src_mac` out 48 each: header fields of the current frame.
- `rx_eth_type` out 16: header field of the current frame.
- `rx_hdr_valid` out 1: one-cycle pulse when the header is complete and the frame is accepted.
- `good_frames`, `bad_frames` out 16 each: wrapping counters.

## Operation
- States: IDLE, PREAMBLE, HEADER, PAYLOAD, DROP.
- **IDLE**
  - `rx_dv`=1 with nibble 0x5 -> PREAMBLE.
  - `rx_dv`=1 with any other nibble -> DROP.
- **PREAMBLE**
  - Nibble 0x5: stay.
  - Nibble 0xD: SFD. Clear the nibble phase, byte index and error flag; set CRC to 0xFFFFFFFF; go to HEADER.
  - Any other nibble -> DROP.
  - `rx_dv`=0 -> IDLE.
- **Byte assembly:** first nibble -> `[3:0]`, second nibble -> `[7:4]`. The byte is complete on the second nibble.
- **CRC:** reflected CRC-32, polynomial 0xEDB88320, LSB first. Runs over every byte from the first destination-MAC byte through the last FCS byte. The frame is good iff the final register equals 0xDEBB20E3.
- **HEADER**
  - Bytes 0-5 form `rx_dst_mac` (byte 0 = `[47:40]`), bytes 6-11 form `rx_src_mac`, bytes 12-13 form `rx_eth_type` (big-endian).
  - After byte 5, the destination must match `local_mac`, or be broadcast with `ACCEPT_BCAST`, or `PROMISC` must be set. Otherwise -> DROP.
  - After byte 13: pulse `rx_hdr_valid`, go to PAYLOAD.
- **PAYLOAD**
  - Each completed byte enters a 5-deep byte delay line. Once the line is full, each new byte pushes out the oldest one as a `tvalid` beat with `tlast`=0.
  - On `rx_dv` falling: if the line holds 5 bytes, the oldest is the last payload byte. The other 4 bytes are FCS. Emit the oldest byte with `tlast`=1 and `tuser`=error, where error = CRC bad | `rx_er` seen | odd nibble phase. Increment `good_frames` or `bad_frames` to match.
  - If `rx_dv` falls with fewer than 5 bytes in the line (zero payload): emit nothing and increment `bad_frames`.
- **DROP:** no output; wait for `rx_dv`=0, then IDLE. Filtered frames do not touch the counters.
- **`rx_dv` falling inside HEADER** (runt): no output, increment `bad_frames`, go to IDLE.
- **`rx_er`** in HEADER or PAYLOAD sets a sticky error flag for the frame.

## Timing
- Reset values:
  - All stream outputs 0.
  - `rx_hdr_valid` 0.
  - MAC and type registers 0.
  - Counters 0.
  - State IDLE.
- Outputs are registered.
- Payload latency: byte N is emitted 1 cycle after the second nibble of byte N+5 is sampled.
- `tlast` beat: 1 cycle after the first sample with `rx_dv`=0.
- `rx_hdr_valid`: 1 cycle after the second nibble of byte 13.
- `tvalid` beats are at least 2 cycles apart. The `tlast` beat can follow the previous beat by exactly 1 cycle.
- A new preamble may start 1 cycle after `rx_dv` falls; the `tlast` emission and the new frame's IDLE->PREAMBLE transition occur in the same cycle.
- Reset mid-frame: all outputs clear immediately and the partial frame is discarded.

## Test plan
- **Good frame, unicast.** Send 7×0x55, 0xD5, dst=`local_mac`=02:00:00:00:00:01, src 02:00:00:00:00:02, type 0x0800, 46 payload bytes 0x00..0x2D, correct FCS.
  - Required: 46 beats 0x00..0x2D; `tlast` on 0x2D with `tuser`=0.
  - Required: `rx_eth_type`=0x0800, `rx_hdr_valid` pulsed once, `good_frames`=1.
- **Same frame with one payload bit flipped.** Required: 46 beats; `tuser`=1 on `tlast`; `bad_frames`=1.
- **Destination filtering.** Destination 02:00:00:00:00:09 -> no beats, no `rx_hdr_valid`, counters unchanged. Destination FF:FF:FF:FF:FF:FF with `ACCEPT_BCAST`=1 -> frame delivered.
- **Runt.** `rx_dv` drops after header byte 8 -> no beats; `bad_frames` +1; a following good frame is delivered correctly.
- **Errors in payload.** `rx_er` pulsed during payload -> `tuser`=1. An extra nibble before `rx_dv` falls -> `tuser`=1.
- **Reset mid-frame.** Assert `rst_n` low during payload byte 20 -> all outputs 0 immediately. After release, a back-to-back good frame is delivered intact.
